// File: rtl/cdf_pkg.sv
// Shared constants for the connected-domain filter window-mask sequencer.
//   MASK_W / IDX_W : mask width and bound-index width (must match the generator)
//   state_t        : sequencer states
//   LR_LEFT/RIGHT  : generator pass select encoding
package cdf_pkg;

    localparam int unsigned MASK_W = 512;
    localparam int unsigned IDX_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ_L = 3'd1,
        GAP_L = 3'd2,
        REQ_R = 3'd3,
        GAP_R = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage : cdf_pkg

// File: rtl/cdf_window_mask_ctrl.sv
// Window-mask sequencer: masters the external mask generator for a left pass
// then a right pass, and ANDs the two results into the window mask.
// Upstream uses the same four-phase trig/done handshake as the generator.
//
// Ports:
//   i_clk, i_rstn        clock (rising edge), async active-low reset
//   i_trig               request, held until o_done seen
//   i_left_bound         ones shifted in from the MSB side
//   i_right_bound        ones shifted in from the LSB side
//   i_invert             (only with CDF_MASK_INVERT_EN) produce exclusion mask
//   o_done               window mask valid while i_trig is still high
//   o_mask               window mask, held between requests
//   o_mg_trig            generator trigger
//   o_mg_left_or_right   generator pass select (0 left, 1 right)
//   o_mg_bound_index     generator bound index
//   i_mg_done, i_mg_mask generator done / result
//
// Optional build macro: CDF_MASK_INVERT_EN adds i_invert and output inversion.
module cdf_window_mask_ctrl
    import cdf_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_trig,
    input  logic [IDX_W-1:0]  i_left_bound,
    input  logic [IDX_W-1:0]  i_right_bound,
`ifdef CDF_MASK_INVERT_EN
    input  logic              i_invert,
`endif
    output logic              o_done,
    output logic [MASK_W-1:0] o_mask,
    output logic              o_mg_trig,
    output logic              o_mg_left_or_right,
    output logic [IDX_W-1:0]  o_mg_bound_index,
    input  logic              i_mg_done,
    input  logic [MASK_W-1:0] i_mg_mask
);

    state_t              r_state;
    state_t              w_next;
    logic                w_latch;
    logic                w_cap_l;
    logic                w_cap_r;
    logic [IDX_W-1:0]    r_left_bound;
    logic [IDX_W-1:0]    r_right_bound;
    logic [MASK_W-1:0]   r_left_mask;
    logic [MASK_W-1:0]   r_mask;
    logic [MASK_W-1:0]   w_win;
    logic [MASK_W-1:0]   w_mask_new;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_cap_l = 1'b0;
        w_cap_r = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_trig) begin
                    w_latch = 1'b1;
                    w_next  = REQ_L;
                end
            end
            REQ_L: begin
                if (i_mg_done) begin
                    w_cap_l = 1'b1;
                    w_next  = GAP_L;
                end
            end
            // One low cycle lets the generator fall back to its idle state
            GAP_L: w_next = REQ_R;
            REQ_R: begin
                if (i_mg_done) begin
                    w_cap_r = 1'b1;
                    w_next  = GAP_R;
                end
            end
            GAP_R: w_next = DONE;
            // An early-dropped i_trig exits here at once without a done pulse
            DONE: begin
                if (!i_trig) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Bound latches, left-pass capture and window mask
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_left_bound  <= '0;
            r_right_bound <= '0;
            r_left_mask   <= '0;
            r_mask        <= '0;
        end else begin
            if (w_latch) begin
                r_left_bound  <= i_left_bound;
                r_right_bound <= i_right_bound;
            end
            if (w_cap_l) begin
                r_left_mask <= i_mg_mask;
            end
            if (w_cap_r) begin
                r_mask <= w_mask_new;
            end
        end
    end

    assign w_win = r_left_mask & i_mg_mask;

`ifdef CDF_MASK_INVERT_EN
    logic r_invert;

    // Inversion select travels with the bounds for the whole request
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_invert <= 1'b0;
        end else if (w_latch) begin
            r_invert <= i_invert;
        end
    end

    assign w_mask_new = r_invert ? ~w_win : w_win;
`else
    assign w_mask_new = w_win;
`endif

    // Generator controls decode straight from the state register
    assign o_mg_trig          = (r_state == REQ_L) || (r_state == REQ_R);
    assign o_mg_left_or_right = (r_state == REQ_R) ? LR_RIGHT : LR_LEFT;
    assign o_mg_bound_index   = (r_state == REQ_R) ? r_right_bound : r_left_bound;

    assign o_mask = r_mask;
    assign o_done = (r_state == DONE) && i_trig;

endmodule : cdf_window_mask_ctrl

// File: tb/tb_cdf_window_mask_ctrl.sv
// Bench for cdf_window_mask_ctrl with a behavioural mask generator beside it.
module tb_cdf_window_mask_ctrl;
    import cdf_pkg::*;

    localparam int unsigned LAT = 24;

    typedef struct {
        logic [MASK_W-1:0] mask;
        int                acc;
    } exp_t;

    typedef struct {
        logic             lr;
        logic [IDX_W-1:0] idx;
    } gexp_t;

    logic              clk = 1'b0;
    logic              i_rstn;
    logic              i_trig;
    logic [IDX_W-1:0]  i_left_bound;
    logic [IDX_W-1:0]  i_right_bound;
`ifdef CDF_MASK_INVERT_EN
    logic              i_invert;
`endif
    logic              o_done;
    logic [MASK_W-1:0] o_mask;
    logic              o_mg_trig;
    logic              o_mg_left_or_right;
    logic [IDX_W-1:0]  o_mg_bound_index;
    logic              mg_done;
    logic [MASK_W-1:0] mg_mask;

    int   nvec  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    exp_t  q[$];
    gexp_t gq[$];

    cdf_window_mask_ctrl dut (
        .i_clk              (clk),
        .i_rstn             (i_rstn),
        .i_trig             (i_trig),
        .i_left_bound       (i_left_bound),
        .i_right_bound      (i_right_bound),
`ifdef CDF_MASK_INVERT_EN
        .i_invert           (i_invert),
`endif
        .o_done             (o_done),
        .o_mask             (o_mask),
        .o_mg_trig          (o_mg_trig),
        .o_mg_left_or_right (o_mg_left_or_right),
        .o_mg_bound_index   (o_mg_bound_index),
        .i_mg_done          (mg_done),
        .i_mg_mask          (mg_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural generator: entry cycle, passes, then done held until trig drops
    logic [1:0]       g_st;
    logic [3:0]       g_cnt;
    logic             g_lr;
    logic [IDX_W-1:0] g_idx;
    logic [MASK_W-1:0] g_ones;

    always @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            g_st  <= 2'd0;
            g_cnt <= 4'd0;
            g_lr  <= 1'b0;
            g_idx <= '0;
        end else begin
            case (g_st)
                2'd0: if (o_mg_trig) begin
                    g_st  <= 2'd1;
                    g_cnt <= 4'd0;
                    g_lr  <= o_mg_left_or_right;
                    g_idx <= o_mg_bound_index;
                end
                2'd1: if (g_cnt == 4'd8) g_st <= 2'd2;
                      else g_cnt <= g_cnt + 4'd1;
                default: if (!o_mg_trig) g_st <= 2'd0;
            endcase
        end
    end

    assign g_ones  = '1;
    assign mg_done = (g_st == 2'd2) && o_mg_trig;
    assign mg_mask = g_lr ? ~(g_ones << g_idx) : ~(g_ones >> g_idx);

    task automatic chk(input string name, input logic [MASK_W-1:0] act,
                       input logic [MASK_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference window: bit i set when 512-L <= i < R
    function automatic logic [MASK_W-1:0] win(input int l, input int r, input bit inv);
        logic [MASK_W-1:0] m;
        for (int i = 0; i < int'(MASK_W); i++)
            m[i] = (i >= int'(MASK_W) - l) && (i < r);
        return inv ? ~m : m;
    endfunction

    // Done monitor: each o_done rise pops one expected window and latency
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (o_done && !prev) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", MASK_W'(o_done), '0);
                end else begin
                    e = q.pop_front();
                    chk("window_mask", o_mask, e.mask);
                    chk("done_latency", MASK_W'(cyc - e.acc), MASK_W'(LAT));
                    chk("mg_trig_in_done", MASK_W'(o_mg_trig), '0);
                end
            end
            prev = o_done;
        end
    end

    // Generator-port monitor: pass order, index and the single-cycle gap
    initial begin
        logic  prev;
        int    low_run;
        gexp_t g;
        prev    = 1'b0;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (o_mg_trig && !prev) begin
                if (gq.size() == 0) begin
                    chk("gen_unexpected", MASK_W'(o_mg_trig), '0);
                end else begin
                    g = gq.pop_front();
                    chk("gen_lr", MASK_W'(o_mg_left_or_right), MASK_W'(g.lr));
                    chk("gen_idx", MASK_W'(o_mg_bound_index), MASK_W'(g.idx));
                    if (g.lr) chk("gen_gap", MASK_W'(low_run), MASK_W'(1));
                end
            end
            low_run = o_mg_trig ? 0 : low_run + 1;
            prev    = o_mg_trig;
        end
    end

    task automatic issue(input int l, input int r, input bit inv);
        @(negedge clk);
        i_left_bound  = IDX_W'(l);
        i_right_bound = IDX_W'(r);
`ifdef CDF_MASK_INVERT_EN
        i_invert      = inv;
`endif
        i_trig        = 1'b1;
        gq.push_back('{lr: 1'b0, idx: IDX_W'(l)});
        gq.push_back('{lr: 1'b1, idx: IDX_W'(r)});
    endtask

    task automatic do_req(input int l, input int r, input bit inv);
        exp_t e;
        issue(l, r, inv);
        e.mask = win(l, r, inv);
        e.acc  = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        // Bounds must not be resampled mid-request
        i_left_bound  = ~IDX_W'(l);
        i_right_bound = ~IDX_W'(r);
        for (int k = 0; k < 60 && !o_done; k++) @(negedge clk);
        chk("done_wait", MASK_W'(o_done), MASK_W'(1));
        @(negedge clk);
        i_trig = 1'b0;
        #1;
        chk("done_drop", MASK_W'(o_done), '0);
        repeat (3) @(negedge clk);
        chk("mask_hold", o_mask, e.mask);
    endtask

    task automatic do_abort(input int l, input int r);
        issue(l, r, 1'b0);
        repeat (5) @(negedge clk);
        i_trig = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_mask", o_mask, win(l, r, 1'b0));
    endtask

    task automatic do_reset_mid(input int l, input int r);
        issue(l, r, 1'b0);
        for (int k = 0; k < 60 && !(o_mg_trig && o_mg_left_or_right); k++) @(negedge clk);
        chk("reach_req_r", MASK_W'(o_mg_left_or_right), MASK_W'(1));
        repeat (3) @(negedge clk);
        #2 i_rstn = 1'b0;
        #1;
        chk("rst_mg_trig", MASK_W'(o_mg_trig), '0);
        chk("rst_mask", o_mask, '0);
        chk("rst_done", MASK_W'(o_done), '0);
        i_trig = 1'b0;
        @(negedge clk);
        i_rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        i_rstn        = 1'b0;
        i_trig        = 1'b0;
        i_left_bound  = '0;
        i_right_bound = '0;
`ifdef CDF_MASK_INVERT_EN
        i_invert      = 1'b0;
`endif
        #3;
        chk("reset_mask", o_mask, '0);
        chk("reset_done", MASK_W'(o_done), '0);
        chk("reset_mg_trig", MASK_W'(o_mg_trig), '0);
        chk("reset_mg_lr", MASK_W'(o_mg_left_or_right), '0);
        chk("reset_mg_idx", MASK_W'(o_mg_bound_index), '0);
        repeat (2) @(negedge clk);
        i_rstn = 1'b1;

        do_req(300, 300, 1'b0);
        do_req(256, 256, 1'b0);
        do_req(511, 511, 1'b0);
        do_req(0, 511, 1'b0);
        do_req(1, 511, 1'b0);
        do_abort(100, 450);
        do_req(400, 200, 1'b0);
        do_reset_mid(50, 480);
        do_req(300, 300, 1'b0);
`ifdef CDF_MASK_INVERT_EN
        do_req(300, 300, 1'b1);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", MASK_W'(q.size()), '0);
        chk("gen_queue_empty", MASK_W'(gq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_cdf_window_mask_ctrl
